circuit_in_pack: RTL and testbench

Upstream feeder for the `circuit` datapath. It accepts a narrow DW-bit beat stream with a valid/ready handshake and packs W/DW consecutive beats into one W-bit operand. It then presents that operand on `x` with a single-cycle `en` strobe, which is exactly the operand/enable pair `circuit` consumes. A separate output register holds the operand while the next one is being collected. This removes the hand-driven `x`/`en` stimulus and lets a byte-wide source (UART, FIFO, CPU register) drive the core.

---
 rtl/circuit_in_pack_pkg.sv | 14 +
 rtl/circuit_in_pack.sv | 104 ++++++++++
 tb/tb_circuit_in_pack.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/circuit_in_pack_pkg.sv
// Shared definitions for the circuit operand packer: state encoding and the
// default operand/beat widths used by circuit, this block and its bench.
package circuit_in_pack_pkg;

    // FILL collects beats, PEND holds a complete operand awaiting out_ready
    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } pack_state_t;

    localparam int DEF_W  = 96;
    localparam int DEF_DW = 8;

endpackage

// File: rtl/circuit_in_pack.sv
// Packs W/DW little-endian DW-bit beats into one W-bit operand and presents
// it on x with a one-cycle en strobe. Partial operands can be closed with
// flush (zero padded); out_ready low parks a complete operand in PEND.
module circuit_in_pack
    import circuit_in_pack_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int DW = DEF_DW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DW-1:0]                in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    input  logic                         out_ready,
    output logic [W-1:0]                 x,
    output logic                         en,
    output logic [$clog2(W/DW+1)-1:0]    cnt
);

    localparam int NB = W / DW;
    localparam int CW = $clog2(NB + 1);

    if ((W % DW) != 0) begin : g_w_chk
        $error("circuit_in_pack: W must be a multiple of DW");
    end

    pack_state_t     r_state;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_acc;
    logic [W-1:0]    r_x;
    logic            r_en;

    logic            w_accept;
    logic [CW-1:0]   w_eff_cnt;
    logic [W-1:0]    w_acc_nxt;
    logic            w_complete;

    // Ready depends only on state and reset, never on in_valid
    assign in_ready  = rst && (r_state == FILL);
    assign w_accept  = in_valid && in_ready;
    assign w_eff_cnt = r_cnt + {{(CW-1){1'b0}}, w_accept};

    // Operand closes on the NB-th beat, or on flush with at least one beat
    // in it (counting a beat accepted in the same cycle)
    assign w_complete = (r_state == FILL) &&
                        ((w_eff_cnt == CW'(NB)) || (flush && (w_eff_cnt != '0)));

    // Accumulator with this cycle's beat merged into slot r_cnt
    always_comb begin
        w_acc_nxt = r_acc;
        for (int k = 0; k < NB; k++) begin
            if (w_accept && (r_cnt == CW'(k)))
                w_acc_nxt[k*DW +: DW] = in_data;
        end
    end

    // FSM, counter, accumulator and output register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_x     <= '0;
            r_en    <= 1'b0;
        end else begin
            r_en <= 1'b0;
            case (r_state)
                FILL: begin
                    if (w_complete && out_ready) begin
                        // Clearing the accumulator keeps later padding zero
                        r_x   <= w_acc_nxt;
                        r_en  <= 1'b1;
                        r_cnt <= '0;
                        r_acc <= '0;
                    end else if (w_complete) begin
                        r_state <= PEND;
                        r_acc   <= w_acc_nxt;
                        r_cnt   <= w_eff_cnt;
                    end else begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= w_eff_cnt;
                    end
                end
                PEND: begin
                    if (out_ready) begin
                        r_x     <= r_acc;
                        r_en    <= 1'b1;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_state <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign x   = r_x;
    assign en  = r_en;
    assign cnt = r_cnt;

endmodule

// File: tb/tb_circuit_in_pack.sv
// Directed bench for circuit_in_pack: a vector table for the basic pack and
// flush behaviour plus hand sequences for reset, back-to-back, backpressure
// and mid-operation reset.
module tb_circuit_in_pack;
    import circuit_in_pack_pkg::*;

    localparam int W  = DEF_W;
    localparam int DW = DEF_DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic          out_ready;
    logic [W-1:0]  x;
    logic          en;
    logic [3:0]    cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    circuit_in_pack #(.W(W), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_ready (out_ready),
        .x         (x),
        .en        (en),
        .cnt       (cnt)
    );

    typedef struct {
        logic         v;
        logic [7:0]   d;
        logic         fl;
        logic         ordy;
        logic         e_en;
        logic [3:0]   e_cnt;
        logic [95:0]  e_x;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then sample 1ns after the edge
    task automatic cyc(input logic v, input logic [7:0] d, input logic fl, input logic ordy);
        in_valid  = v;
        in_data   = d;
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic v, input logic [7:0] d, input logic fl,
                                input logic ordy, input logic e_en, input logic [3:0] e_cnt,
                                input logic [95:0] e_x);
        vec_t r;
        r.v = v; r.d = d; r.fl = fl; r.ordy = ordy;
        r.e_en = e_en; r.e_cnt = e_cnt; r.e_x = e_x;
        tbl.push_back(r);
    endfunction

    initial begin
        int en_cyc[$];
        logic [95:0] en_x[$];

        // Table: full pack, idle, 3-beat flush, empty flush, flush with 5th beat
        for (int k = 0; k < 11; k++)
            add(1'b1, 8'(k + 1), 1'b0, 1'b1, 1'b0, 4'(k + 1), 96'h0);
        add(1'b1, 8'h0C, 1'b0, 1'b1, 1'b1, 4'd0, 96'h0C0B0A090807060504030201);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 96'h0C0B0A090807060504030201);
        add(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 4'd1, 96'h0C0B0A090807060504030201);
        add(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0, 4'd2, 96'h0C0B0A090807060504030201);
        add(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0, 4'd3, 96'h0C0B0A090807060504030201);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'd0, 96'h00CCBBAA);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 96'h00CCBBAA);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 96'h00CCBBAA);
        add(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 4'd1, 96'h00CCBBAA);
        add(1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 4'd2, 96'h00CCBBAA);
        add(1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 4'd3, 96'h00CCBBAA);
        add(1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 4'd4, 96'h00CCBBAA);
        add(1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 4'd0, 96'h5544332211);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 96'h5544332211);

        // Reset held 3 cycles with in_valid high
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h5A, 1'b0, 1'b1);
            chk("rst_x", x, 96'h0);
            chk("rst_en", {95'h0, en}, 96'h0);
            chk("rst_in_ready", {95'h0, in_ready}, 96'h0);
            chk("rst_cnt", {92'h0, cnt}, 96'h0);
        end
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("rel_in_ready", {95'h0, in_ready}, 96'h1);
        chk("rel_cnt", {92'h0, cnt}, 96'h0);

        // Table-driven vectors
        foreach (tbl[i]) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].fl, tbl[i].ordy);
            chk($sformatf("tbl%0d_en", i), {95'h0, en}, {95'h0, tbl[i].e_en});
            chk($sformatf("tbl%0d_cnt", i), {92'h0, cnt}, {92'h0, tbl[i].e_cnt});
            chk($sformatf("tbl%0d_x", i), x, tbl[i].e_x);
            chk($sformatf("tbl%0d_rdy", i), {95'h0, in_ready}, 96'h1);
        end

        // Back-to-back: 24 continuous beats, in_ready must never drop
        for (int k = 0; k < 24; k++) begin
            chk("b2b_in_ready", {95'h0, in_ready}, 96'h1);
            cyc(1'b1, 8'(k), 1'b0, 1'b1);
            if (en) begin
                en_cyc.push_back(k);
                en_x.push_back(x);
            end
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("b2b_en_count", 96'(en_cyc.size()), 96'd2);
        if (en_cyc.size() == 2) begin
            chk("b2b_first_cyc", 96'(en_cyc[0]), 96'd11);
            chk("b2b_spacing", 96'(en_cyc[1] - en_cyc[0]), 96'd12);
            chk("b2b_x0", en_x[0], 96'h0B0A09080706050403020100);
            chk("b2b_x1", en_x[1], 96'h17161514131211100F0E0D0C);
        end

        // Backpressure: out_ready low as beat 12 lands, held 5 cycles
        for (int k = 0; k < 12; k++)
            cyc(1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
        chk("bp_cnt", {92'h0, cnt}, 96'd12);
        chk("bp_en", {95'h0, en}, 96'h0);
        chk("bp_in_ready", {95'h0, in_ready}, 96'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'hEE, 1'b1, 1'b0);
            chk("bp_hold_en", {95'h0, en}, 96'h0);
            chk("bp_hold_rdy", {95'h0, in_ready}, 96'h0);
        end
        cyc(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("bp_rel_en", {95'h0, en}, 96'h1);
        chk("bp_rel_x", x, 96'h3B3A393837363534_33323130);
        chk("bp_rel_rdy", {95'h0, in_ready}, 96'h1);
        chk("bp_rel_cnt", {92'h0, cnt}, 96'h0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("bp_after_en", {95'h0, en}, 96'h0);

        // Mid-operation reset after 7 beats: no en, no residue afterwards
        for (int k = 0; k < 7; k++)
            cyc(1'b1, 8'(8'hE0 + k), 1'b0, 1'b1);
        chk("mr_cnt7", {92'h0, cnt}, 96'd7);
        rst = 1'b0;
        cyc(1'b1, 8'hFF, 1'b1, 1'b1);
        chk("mr_en", {95'h0, en}, 96'h0);
        chk("mr_cnt", {92'h0, cnt}, 96'h0);
        chk("mr_x", x, 96'h0);
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cyc(1'b1, 8'(8'h40 + k), 1'b0, 1'b1);
            chk("mr_en_pulse", {95'h0, en}, (k == 11) ? 96'h1 : 96'h0);
        end
        chk("mr_x_clean", x, 96'h4B4A49484746454443424140);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("mr_en_single", {95'h0, en}, 96'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
